// File: rtl/ex_pkg.sv
// Shared types for the execute stage: short op codes, divider FSM states, helpers.
package ex_pkg;

  localparam int unsigned AddressBus    = 32;
  localparam int unsigned RegBus        = 32;
  localparam int unsigned RegAddressBus = 5;
  localparam int unsigned CSRAddressBus = 12;
  localparam int unsigned InstShort     = 6;

  // Short op codes carried down the pipeline; zero is a bubble.
  typedef enum logic [InstShort-1:0] {
    InstNop    = 6'd0,
    InstLui    = 6'd1,
    InstAuipc  = 6'd2,
    InstJal    = 6'd3,
    InstJalr   = 6'd4,
    InstBeq    = 6'd5,
    InstBne    = 6'd6,
    InstBlt    = 6'd7,
    InstBge    = 6'd8,
    InstBltu   = 6'd9,
    InstBgeu   = 6'd10,
    InstLb     = 6'd11,
    InstLh     = 6'd12,
    InstLw     = 6'd13,
    InstLbu    = 6'd14,
    InstLhu    = 6'd15,
    InstSb     = 6'd16,
    InstSh     = 6'd17,
    InstSw     = 6'd18,
    InstAddi   = 6'd19,
    InstSlti   = 6'd20,
    InstSltiu  = 6'd21,
    InstXori   = 6'd22,
    InstOri    = 6'd23,
    InstAndi   = 6'd24,
    InstSlli   = 6'd25,
    InstSrli   = 6'd26,
    InstSrai   = 6'd27,
    InstAdd    = 6'd28,
    InstSub    = 6'd29,
    InstSll    = 6'd30,
    InstSlt    = 6'd31,
    InstSltu   = 6'd32,
    InstXor    = 6'd33,
    InstSrl    = 6'd34,
    InstSra    = 6'd35,
    InstOr     = 6'd36,
    InstAnd    = 6'd37,
    InstCsrrw  = 6'd38,
    InstCsrrs  = 6'd39,
    InstCsrrc  = 6'd40,
    InstCsrrwi = 6'd41,
    InstCsrrsi = 6'd42,
    InstCsrrci = 6'd43,
    InstMul    = 6'd44,
    InstMulh   = 6'd45,
    InstMulhsu = 6'd46,
    InstMulhu  = 6'd47,
    InstDiv    = 6'd48,
    InstDivu   = 6'd49,
    InstRem    = 6'd50,
    InstRemu   = 6'd51
  } inst_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  function automatic logic is_div_op(inst_e op);
    return (op == InstDiv) || (op == InstDivu) || (op == InstRem) || (op == InstRemu);
  endfunction

endpackage

// File: rtl/ex_if.sv
// Execute-stage bus: operands from ID/EX in, writeback/memory/redirect/stall out.
interface ex_if;
  import ex_pkg::*;

  logic                     rdy_in;
  logic [AddressBus-1:0]    pc_in;
  logic [RegBus-1:0]        rs1_in;
  logic [RegBus-1:0]        rs2_in;
  logic [RegAddressBus-1:0] rd_in;
  logic [RegBus-1:0]        imm_in;
  inst_e                    inst_in;
  logic [CSRAddressBus-1:0] csr_in;
  logic [RegBus-1:0]        csr_data_in;

  logic [RegAddressBus-1:0] rd_out;
  logic [RegBus-1:0]        rd_data_out;
  logic                     rd_enable_out;
  logic [AddressBus-1:0]    mem_addr_out;
  logic [RegBus-1:0]        mem_data_out;
  inst_e                    inst_out;
  logic [CSRAddressBus-1:0] csr_out;
  logic [RegBus-1:0]        csr_data_out;
  logic                     jump_enable;
  logic [AddressBus-1:0]    jump_addr;
  logic                     stall_req;

  // Upstream side (ID/EX register and downstream consumers).
  modport master (
    output rdy_in, pc_in, rs1_in, rs2_in, rd_in, imm_in, inst_in, csr_in, csr_data_in,
    input  rd_out, rd_data_out, rd_enable_out, mem_addr_out, mem_data_out, inst_out,
           csr_out, csr_data_out, jump_enable, jump_addr, stall_req
  );

  // Execute stage itself.
  modport slave (
    input  rdy_in, pc_in, rs1_in, rs2_in, rd_in, imm_in, inst_in, csr_in, csr_data_in,
    output rd_out, rd_data_out, rd_enable_out, mem_addr_out, mem_data_out, inst_out,
           csr_out, csr_data_out, jump_enable, jump_addr, stall_req
  );

endinterface

// File: rtl/ex_div.sv
// 32-iteration restoring divider with fast paths for divide-by-zero and signed overflow.
module ex_div
  import ex_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              start,
  input  logic              is_signed,
  input  logic              rem_sel,
  input  logic [RegBus-1:0] dividend,
  input  logic [RegBus-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [RegBus-1:0] result
);

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] quo_q, quo_d;
  logic [RegBus-1:0] rem_q, rem_d;
  logic [RegBus-1:0] dvsr_q, dvsr_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              sel_q, sel_d;

  logic [RegBus-1:0] dvd_abs, dvs_abs;
  logic [RegBus:0]   shifted, diff;
  logic [RegBus-1:0] quo_fix, rem_fix;

  assign dvd_abs = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign dvs_abs = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // Partial remainder is always below the divisor, so 33 bits hold the shifted value.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};

  assign quo_fix = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
  assign result  = done ? (sel_q ? rem_fix : quo_fix) : '0;

  // Next-state: latch operands in idle, one restoring step per busy cycle, release in done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    sel_d     = sel_q;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      DivIdle: begin
        if (start) begin
          busy  = 1'b1;
          sel_d = rem_sel;
          cnt_d = '0;
          if (divisor == '0) begin
            // Remainder is the raw dividend, so no sign fix-up.
            quo_d     = '1;
            rem_d     = dividend;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            state_d   = DivDone;
          end else if (is_signed && (dividend == 32'h8000_0000) && (divisor == '1)) begin
            quo_d     = 32'h8000_0000;
            rem_d     = '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            state_d   = DivDone;
          end else begin
            quo_d     = dvd_abs;
            rem_d     = '0;
            dvsr_d    = dvs_abs;
            quo_neg_d = is_signed & (dividend[31] ^ divisor[31]);
            rem_neg_d = is_signed & dividend[31];
            state_d   = DivBusy;
          end
        end
      end
      DivBusy: begin
        busy  = 1'b1;
        quo_d = {quo_q[30:0], ~diff[RegBus]};
        rem_d = diff[RegBus] ? shifted[RegBus-1:0] : diff[RegBus-1:0];
        if (cnt_q == 5'd31) begin
          cnt_d   = '0;
          state_d = DivDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DivDone: begin
        done    = 1'b1;
        state_d = DivIdle;
      end
      default: state_d = DivIdle;
    endcase
  end

  // State registers: synchronous reset, frozen while the pipeline is not ready.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= DivIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      sel_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: rtl/ex.sv
// RV32IM execute stage: combinational ALU, branch resolution, CSR write data, multiply,
// and a multi-cycle divider that stalls the front of the pipeline.
module ex
  import ex_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  ex_if.slave  bus
);

  logic [RegBus-1:0] rs1, rs2, imm, pc;
  logic [RegBus-1:0] rs1_imm, pc_imm, pc_4;
  logic [4:0]        shamt_r, shamt_i;
  logic              lt_s, lt_u, lt_si, lt_ui, eq;
  logic              br_taken;

  logic              mul_a_sgn, mul_b_sgn;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_prod;
  logic              unused_mul;

  logic              div_op, div_signed, div_rem, div_busy, div_done;
  logic [RegBus-1:0] div_result;

  logic [RegBus-1:0] alu_res;
  logic              alu_wr;
  logic [RegBus-1:0] mem_addr, mem_data, csr_wdata, jump_tgt;
  logic [CSRAddressBus-1:0] csr_addr;
  logic              jump_en;

  assign rs1     = bus.rs1_in;
  assign rs2     = bus.rs2_in;
  assign imm     = bus.imm_in;
  assign pc      = bus.pc_in;
  assign rs1_imm = rs1 + imm;
  assign pc_imm  = pc + imm;
  assign pc_4    = pc + 32'd4;
  assign shamt_r = rs2[4:0];
  assign shamt_i = imm[4:0];
  assign eq      = (rs1 == rs2);
  assign lt_s    = ($signed(rs1) < $signed(rs2));
  assign lt_u    = (rs1 < rs2);
  assign lt_si   = ($signed(rs1) < $signed(imm));
  assign lt_ui   = (rs1 < imm);

  // One 33x33 signed multiplier covers all four variants via operand extension.
  assign mul_a_sgn  = (bus.inst_in == InstMulh) || (bus.inst_in == InstMulhsu);
  assign mul_b_sgn  = (bus.inst_in == InstMulh);
  assign mul_a      = {mul_a_sgn & rs1[31], rs1};
  assign mul_b      = {mul_b_sgn & rs2[31], rs2};
  assign mul_prod   = mul_a * mul_b;
  assign unused_mul = ^mul_prod[65:64];

  assign div_op     = is_div_op(bus.inst_in);
  assign div_signed = (bus.inst_in == InstDiv) || (bus.inst_in == InstRem);
  assign div_rem    = (bus.inst_in == InstRem) || (bus.inst_in == InstRemu);

  ex_div u_div (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (bus.rdy_in),
    .start     (div_op),
    .is_signed (div_signed),
    .rem_sel   (div_rem),
    .dividend  (rs1),
    .divisor   (rs2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Branch condition decode.
  always_comb begin
    unique case (bus.inst_in)
      InstBeq:  br_taken = eq;
      InstBne:  br_taken = ~eq;
      InstBlt:  br_taken = lt_s;
      InstBge:  br_taken = ~lt_s;
      InstBltu: br_taken = lt_u;
      InstBgeu: br_taken = ~lt_u;
      default:  br_taken = 1'b0;
    endcase
  end

  // Main decode: writeback value, memory address/data, CSR write value, redirect.
  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    csr_addr  = '0;
    csr_wdata = '0;
    jump_en   = 1'b0;
    jump_tgt  = '0;
    unique case (bus.inst_in)
      InstLui:   begin alu_wr = 1'b1; alu_res = imm; end
      InstAuipc: begin alu_wr = 1'b1; alu_res = pc_imm; end
      InstJal: begin
        alu_wr   = 1'b1;
        alu_res  = pc_4;
        jump_en  = 1'b1;
        jump_tgt = pc_imm;
      end
      InstJalr: begin
        alu_wr   = 1'b1;
        alu_res  = pc_4;
        jump_en  = 1'b1;
        jump_tgt = {rs1_imm[31:1], 1'b0};
      end
      InstBeq, InstBne, InstBlt, InstBge, InstBltu, InstBgeu: begin
        jump_en  = br_taken;
        jump_tgt = br_taken ? pc_imm : '0;
      end
      // Load data arrives in MEM; EX only supplies the address and claims rd.
      InstLb, InstLh, InstLw, InstLbu, InstLhu: begin
        alu_wr   = 1'b1;
        mem_addr = rs1_imm;
      end
      InstSb, InstSh, InstSw: begin
        mem_addr = rs1_imm;
        mem_data = rs2;
      end
      InstAddi:  begin alu_wr = 1'b1; alu_res = rs1_imm; end
      InstSlti:  begin alu_wr = 1'b1; alu_res = {31'b0, lt_si}; end
      InstSltiu: begin alu_wr = 1'b1; alu_res = {31'b0, lt_ui}; end
      InstXori:  begin alu_wr = 1'b1; alu_res = rs1 ^ imm; end
      InstOri:   begin alu_wr = 1'b1; alu_res = rs1 | imm; end
      InstAndi:  begin alu_wr = 1'b1; alu_res = rs1 & imm; end
      InstSlli:  begin alu_wr = 1'b1; alu_res = rs1 << shamt_i; end
      InstSrli:  begin alu_wr = 1'b1; alu_res = rs1 >> shamt_i; end
      InstSrai:  begin alu_wr = 1'b1; alu_res = 32'($signed(rs1) >>> shamt_i); end
      InstAdd:   begin alu_wr = 1'b1; alu_res = rs1 + rs2; end
      InstSub:   begin alu_wr = 1'b1; alu_res = rs1 - rs2; end
      InstSll:   begin alu_wr = 1'b1; alu_res = rs1 << shamt_r; end
      InstSlt:   begin alu_wr = 1'b1; alu_res = {31'b0, lt_s}; end
      InstSltu:  begin alu_wr = 1'b1; alu_res = {31'b0, lt_u}; end
      InstXor:   begin alu_wr = 1'b1; alu_res = rs1 ^ rs2; end
      InstSrl:   begin alu_wr = 1'b1; alu_res = rs1 >> shamt_r; end
      InstSra:   begin alu_wr = 1'b1; alu_res = 32'($signed(rs1) >>> shamt_r); end
      InstOr:    begin alu_wr = 1'b1; alu_res = rs1 | rs2; end
      InstAnd:   begin alu_wr = 1'b1; alu_res = rs1 & rs2; end
      // CSR ops return the old value; immediate forms carry zimm in imm_in.
      InstCsrrw, InstCsrrs, InstCsrrc, InstCsrrwi, InstCsrrsi, InstCsrrci: begin
        alu_wr   = 1'b1;
        alu_res  = bus.csr_data_in;
        csr_addr = bus.csr_in;
        unique case (bus.inst_in)
          InstCsrrw:  csr_wdata = rs1;
          InstCsrrs:  csr_wdata = bus.csr_data_in | rs1;
          InstCsrrc:  csr_wdata = bus.csr_data_in & ~rs1;
          InstCsrrwi: csr_wdata = imm;
          InstCsrrsi: csr_wdata = bus.csr_data_in | imm;
          default:    csr_wdata = bus.csr_data_in & ~imm;
        endcase
      end
      InstMul:   begin alu_wr = 1'b1; alu_res = mul_prod[31:0]; end
      InstMulh, InstMulhsu, InstMulhu: begin
        alu_wr  = 1'b1;
        alu_res = mul_prod[63:32];
      end
      // Nothing is written until the divider holds the final result.
      InstDiv, InstDivu, InstRem, InstRemu: begin
        alu_wr  = div_done;
        alu_res = div_result;
      end
      default: ;
    endcase
  end

  assign bus.rd_out        = alu_wr ? bus.rd_in : '0;
  assign bus.rd_data_out   = alu_res;
  assign bus.rd_enable_out = alu_wr;
  assign bus.mem_addr_out  = mem_addr;
  assign bus.mem_data_out  = mem_data;
  // A divide still in flight is a bubble to EX/MEM.
  assign bus.inst_out      = (div_op && !div_done) ? InstNop : bus.inst_in;
  assign bus.csr_out       = csr_addr;
  assign bus.csr_data_out  = csr_wdata;
  assign bus.jump_enable   = jump_en;
  assign bus.jump_addr     = jump_tgt;
  assign bus.stall_req     = div_busy;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage with a writeback scoreboard.
module tb_ex;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];

  ex_if bus ();

  ex dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input inst_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc);
    bus.inst_in     = op;
    bus.rs1_in      = a;
    bus.rs2_in      = b;
    bus.imm_in      = im;
    bus.pc_in       = pc;
    bus.rd_in       = 5'd9;
    bus.csr_in      = 12'h300;
    bus.csr_data_in = 32'h0000_00F0;
  endtask

  // Apply an op, wait out any stall (bounded), then check stall length and writeback.
  // Returns at the negedge of the result cycle with inputs still applied.
  task automatic run(input string tag, input inst_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                     input logic wr, input logic [31:0] val, input int exp_stall,
                     input int gap_at, input int gap_len);
    int stalls = 0;
    bit seen = 1'b0;
    drive(op, a, b, im, pc);
    if (wr) exp_q.push_back(val);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.stall_req) begin
        stalls++;
        chk({tag, "_noen"}, {31'b0, bus.rd_enable_out}, 32'd0);
        if (gap_len != 0 && stalls == gap_at) bus.rdy_in = 1'b0;
        if (gap_len != 0 && stalls == gap_at + gap_len) bus.rdy_in = 1'b1;
      end else begin
        seen = 1'b1;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL %s_timeout: got stall still high want result", tag);
    end
    chk({tag, "_stall"}, stalls, exp_stall);
    chk({tag, "_en"}, {31'b0, bus.rd_enable_out}, {31'b0, wr});
    if (bus.rd_enable_out && exp_q.size() != 0) chk(tag, bus.rd_data_out, exp_q.pop_front());
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    drive(InstNop, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0044, 32'h0000_0400);
  endtask

  initial begin
    int stalls;
    bus.rdy_in = 1'b1;
    drive(InstNop, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0044, 32'h0000_0400);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Bubble in EX: every output is zero.
    @(negedge clk);
    chk("rst_rd_data", bus.rd_data_out, 32'd0);
    chk("rst_rd_en", {31'b0, bus.rd_enable_out}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("rst_jump", {31'b0, bus.jump_enable}, 32'd0);
    chk("rst_inst", {26'b0, bus.inst_out}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
    chk("rst_csr_data", bus.csr_data_out, 32'd0);
    next();

    run("add", InstAdd, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1, 32'd12, 0, 0, 0);
    chk("add_rd", {27'b0, bus.rd_out}, 32'd9);
    next();
    run("sub", InstSub, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
    next();
    run("sra", InstSra, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 1'b1, 32'hF800_0000, 0, 0, 0);
    next();
    run("sltu", InstSltu, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'd1, 0, 0, 0);
    next();
    run("slt", InstSlt, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'd0, 0, 0, 0);
    next();
    run("lui", InstLui, 32'd0, 32'd0, 32'h1234_5000, 32'h0, 1'b1, 32'h1234_5000, 0, 0, 0);
    next();

    run("beq", InstBeq, 32'd3, 32'd3, 32'h20, 32'h100, 1'b0, 32'd0, 0, 0, 0);
    chk("beq_jump", {31'b0, bus.jump_enable}, 32'd1);
    chk("beq_addr", bus.jump_addr, 32'h120);
    chk("beq_rd", {27'b0, bus.rd_out}, 32'd0);
    next();
    run("bne", InstBne, 32'd3, 32'd3, 32'h20, 32'h100, 1'b0, 32'd0, 0, 0, 0);
    chk("bne_jump", {31'b0, bus.jump_enable}, 32'd0);
    next();
    run("jalr", InstJalr, 32'h1001, 32'd0, 32'h10, 32'h200, 1'b1, 32'h204, 0, 0, 0);
    chk("jalr_jump", {31'b0, bus.jump_enable}, 32'd1);
    chk("jalr_addr", bus.jump_addr, 32'h1010);
    next();

    run("sw", InstSw, 32'h1000, 32'hDEAD_BEEF, 32'd8, 32'h0, 1'b0, 32'd0, 0, 0, 0);
    chk("sw_addr", bus.mem_addr_out, 32'h1008);
    chk("sw_data", bus.mem_data_out, 32'hDEAD_BEEF);
    next();
    run("csrrs", InstCsrrs, 32'h0F, 32'd0, 32'd0, 32'h0, 1'b1, 32'hF0, 0, 0, 0);
    chk("csrrs_wdata", bus.csr_data_out, 32'hFF);
    chk("csrrs_addr", {20'b0, bus.csr_out}, 32'h300);
    next();

    run("mulh", InstMulh, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h0, 1'b1, 32'h4000_0000,
        0, 0, 0);
    next();
    run("mulhsu", InstMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFF,
        0, 0, 0);
    next();
    run("mulhu", InstMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFE,
        0, 0, 0);
    next();
    run("mul", InstMul, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFD, 0, 0, 0);
    next();

    run("div", InstDiv, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFD, 33, 0, 0);
    chk("div_inst", {26'b0, bus.inst_out}, {26'b0, InstDiv});
    next();
    // Five frozen cycles in the middle stretch the stall by five.
    run("rem", InstRem, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, 38, 10, 5);
    next();
    run("divu0", InstDivu, 32'd10, 32'd0, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1, 0, 0);
    next();
    run("rem_ovf", InstRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'd0, 1, 0, 0);
    next();
    run("div_ovf", InstDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 32'h8000_0000,
        1, 0, 0);
    next();
    run("rem0", InstRem, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFB, 1, 0, 0);
    next();
    run("remu", InstRemu, 32'd100, 32'd7, 32'd0, 32'h0, 1'b1, 32'd2, 33, 0, 0);
    next();

    // Reset in the middle of a divide (counter at 10) abandons it.
    drive(InstDiv, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h0);
    stalls = 0;
    for (int c = 0; c < 40 && stalls < 12; c++) begin
      @(negedge clk);
      if (bus.stall_req) stalls++;
    end
    chk("rst_mid_pre", stalls, 32'd12);
    rst = 1'b1;
    drive(InstNop, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0044, 32'h0000_0400);
    @(negedge clk);
    chk("rst_mid_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("rst_mid_en", {31'b0, bus.rd_enable_out}, 32'd0);
    rst = 1'b0;
    next();
    run("divu_after_rst", InstDivu, 32'd100, 32'd7, 32'd0, 32'h0, 1'b1, 32'd14, 33, 0, 0);
    next();

    @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage RV32 pipeline, directly downstream of the ID/EX register and feeding the EX/MEM register. It holds the combinational RV32I ALU, branch/jump resolution and CSR write-value computation. It also adds an RV32M unit: single-cycle multiply and a 32-iteration restoring divider. The divider stalls the front of the pipeline through the stall controller while it runs.

## Interface
- No parameters; widths come from `defines.v` (`AddressBus`/`RegBus` 32, `RegAddressBus` 5, `CSRAddressBus` 12, `InstShort`).
- One clock; reset is synchronous and active-high: `clk_in` (input, 1, clock) and `rst_in` (input, 1, reset).
- rdy_in  input  1  global ready; 0 freezes all state.
- pc_in  input  32  instruction PC from ID/EX.
- rs1_in, rs2_in  input  32  operand values.
- rd_in  input  5  destination register.
- imm_in  input  32  immediate.
- inst_in  input  `InstShort`  short op code; 0 = NOP.
- csr_in  input  12  CSR address.
- csr_data_in  input  32  current CSR value.
- rd_out  output  5  destination; 0 when no write.
- rd_data_out  output  32  writeback value, also forwarded to ID.
- rd_enable_out  output  1  register write enable.
- mem_addr_out  output  32  load/store address (rs1+imm).
- mem_data_out  output  32  store data (rs2).
- inst_out  output  `InstShort`  op code passed to EX/MEM.
- csr_out  output  12  CSR address.
- csr_data_out  output  32  CSR write value.
- jump_enable  output  1  taken branch/JAL/JALR; flushes IF/ID and ID/EX.
- jump_addr  output  32  redirect target.
- stall_req  output  1  request to the stall controller; holds stages 0..3.

## Operation
- All outputs are combinational functions of the inputs and divider state. With ID/EX in reset (inst 0), every output is 0.
- RV32I ops follow the ISA. JALR target is (rs1+imm) with bit 0 cleared. Branch/JAL targets are pc+imm. JAL/JALR write pc+4.
- MUL/MULH/MULHSU/MULHU: one 33x33 signed product of sign- or zero-extended operands. MUL takes the low 32 bits; the others take bits 63:32. No stall.
- DIV/DIVU/REM/REMU use sub-module FSM states IDLE, DIV, DONE:
  - IDLE, divide op present: latch |dividend| and |divisor| (raw for unsigned), the result sign, the rem/quo select and a 5-bit counter=0.
    - Divisor 0 → DONE with quotient 0xFFFFFFFF, remainder = dividend.
    - Signed 0x80000000 / -1 → DONE with quotient 0x80000000, remainder 0.
    - Otherwise → DIV.
  - DIV: one restoring step per cycle, MSB first. When counter==31 → DONE; otherwise counter+1.
  - DONE: drive the sign-corrected result on rd_data_out. The remainder takes the dividend's sign. → IDLE.
- stall_req = (IDLE && divide op) || DIV. It is 0 in DONE, so ID/EX advances on the DONE-exit edge and the same instruction is never restarted.
- rd_enable_out and the result are valid only in DONE. In IDLE/DIV, rd_out and rd_enable_out are 0, so no stale forwarding occurs.
- rdy_in=0: FSM and counter hold. rst_in=1 in any state → IDLE, counter 0, stall_req 0 next cycle.

## Timing
- ALU, multiply, branch: 0-cycle combinational; one instruction per clock.
- Normal divide: the instruction occupies EX for 34 cycles (1 IDLE + 32 DIV + 1 DONE). stall_req is high for 33 of them.
- Special-case divide: 2 cycles (IDLE → DONE).
- jump_enable is never asserted together with stall_req, because divides never jump.
- Counter wraps 31→0 only on the DIV→DONE transition.

## Structure
- `defines.v` gains the short codes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus FSM state encodings `DivIdle`/`DivBusy`/`DivDone` (2 bits).
- One sub-module, `ex_div`: owns the FSM, the counter and the quotient/remainder registers. Its interface is start, signed, rem-select, operands, busy, done and result.
- The ALU and multiply stay inline in `ex`.

## Test plan
- ADD: rs1=5, rs2=7 → rd_data_out=12, rd_enable_out=1, stall_req=0, same cycle.
- BEQ: rs1=rs2=3, pc=0x100, imm=0x20 → jump_enable=1, jump_addr=0x120, rd_enable_out=0.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHSU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. Both with no stall.
- DIV: -7 / 2 → stall_req high 33 cycles, then rd_data_out=0xFFFFFFFD (-3) for one cycle. The same operands with REM → 0xFFFFFFFF (-1).
- DIVU 10/0 → 0xFFFFFFFF after 2 cycles. REM 0x80000000 / -1 → 0 after 2 cycles.
- rst_in pulsed at DIV counter=10 → FSM returns to IDLE, stall_req=0 with inst 0. A later DIVU 100/7 → 14 after 34 cycles.
